// File: rtl/dmem_responder.sv
// Data-memory responder: registered RAM read port plus an MMIO window at 0xFF0-0xFF4
// holding a free-running timer with compare, a byte TX FIFO and an LED register.
module dmem_responder #(
    parameter int RAM_WORDS  = 2048,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        proc_clock,
    input  logic [11:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] led
);
    localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [11:0] A_CNT    = 12'hFF0;
    localparam logic [11:0] A_CMP    = 12'hFF1;
    localparam logic [11:0] A_STATUS = 12'hFF2;
    localparam logic [11:0] A_TX     = 12'hFF3;
    localparam logic [11:0] A_LED    = 12'hFF4;

    logic [31:0] ram [RAM_WORDS];

    logic          pc_q;
    logic [31:0]   q_dmem_q, q_dmem_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [31:0]   cmp_q, cmp_d;
    logic          hit_q, hit_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   led_q, led_d;
    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [7:0]    fifo_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic        stb, mmio_we, in_ram, ram_we;
    logic        wr_cnt, wr_cmp, wr_st, wr_tx, wr_led;
    logic        full, pop, push_ok, ovf_set;
    logic [31:0] ram_rd, status;

    // One-clock strobe on the rising edge of the processor clock, so a store
    // held for a whole processor cycle triggers its side effect only once.
    assign stb     = proc_clock & ~pc_q;
    assign mmio_we = wren & stb;
    assign in_ram  = address_dmem < 12'(RAM_WORDS);
    assign ram_we  = wren & in_ram;
    assign ram_rd  = ram[address_dmem[AW-1:0]];

    assign wr_cnt = mmio_we && (address_dmem == A_CNT);
    assign wr_cmp = mmio_we && (address_dmem == A_CMP);
    assign wr_st  = mmio_we && (address_dmem == A_STATUS);
    assign wr_tx  = mmio_we && (address_dmem == A_TX);
    assign wr_led = mmio_we && (address_dmem == A_LED);

    assign full     = count_q == CW'(FIFO_DEPTH);
    assign tx_valid = count_q != '0;
    assign pop      = tx_valid & tx_ready;
    assign push_ok  = wr_tx & (~full | pop);
    assign ovf_set  = wr_tx & full & ~pop;

    assign status = {23'd0, 5'(count_q), (count_q == '0), full, ovf_q, hit_q};

    always_ff @(posedge clock) begin
        if (ram_we) begin
            ram[address_dmem[AW-1:0]] <= data;
        end
    end

    always_comb begin
        q_dmem_d = 32'd0;
        case (address_dmem)
            A_CNT:    q_dmem_d = cnt_q;
            A_CMP:    q_dmem_d = cmp_q;
            A_STATUS: q_dmem_d = status;
            A_LED:    q_dmem_d = {16'd0, led_q};
            default:  q_dmem_d = in_ram ? ram_rd : 32'd0;
        endcase
    end

    always_comb begin
        cnt_d = wr_cnt ? data : cnt_q + 32'd1;
        cmp_d = wr_cmp ? data : cmp_q;
        led_d = wr_led ? data[15:0] : led_q;
        // A set landing together with a clear must win.
        hit_d = (cnt_q == cmp_q) | (hit_q & ~(wr_st & data[0]));
        ovf_d = ovf_set | (ovf_q & ~(wr_st & data[1]));
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            fifo_d[wr_ptr_q] = data[7:0];
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q     <= 1'b0;
            q_dmem_q <= 32'd0;
            cnt_q    <= 32'd0;
            cmp_q    <= 32'hFFFF_FFFF;
            hit_q    <= 1'b0;
            ovf_q    <= 1'b0;
            led_q    <= 16'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= 8'd0;
            end
        end else begin
            pc_q     <= proc_clock;
            q_dmem_q <= q_dmem_d;
            cnt_q    <= cnt_d;
            cmp_q    <= cmp_d;
            hit_q    <= hit_d;
            ovf_q    <= ovf_d;
            led_q    <= led_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            fifo_q   <= fifo_d;
        end
    end

    assign q_dmem  = q_dmem_q;
    assign tx_data = fifo_q[rd_ptr_q];
    assign led     = led_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a per-clock reference model feeds a scoreboard of expected
// read data and TX bytes; independent monitors compare whenever the DUT presents them.
module tb_dmem_responder;
    localparam int RAM_WORDS = 2048;
    localparam int DEPTH     = 8;

    logic        clock = 1'b0;
    logic        reset, proc_clock, wren, tx_ready;
    logic [11:0] address_dmem;
    logic [31:0] data;
    logic [31:0] q_dmem;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic [15:0] led;

    dmem_responder #(.RAM_WORDS(RAM_WORDS), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .proc_clock(proc_clock),
        .address_dmem(address_dmem), .data(data), .wren(wren),
        .q_dmem(q_dmem), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .led(led)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rdy_mode;
    logic rd_chk;

    typedef struct {
        int          due;
        logic [11:0] addr;
        logic [31:0] val;
    } exp_t;
    exp_t       sb[$];
    logic [7:0] exp_tx[$];

    logic [31:0] m_ram [int];
    logic [31:0] m_cnt, m_cmp;
    logic        m_hit, m_ovf, m_pc;
    int          m_n;
    logic [15:0] m_led;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [11:0] a);
        if (a < 12'(RAM_WORDS)) return m_ram.exists(int'(a)) ? m_ram[int'(a)] : 32'd0;
        case (a)
            12'hFF0: return m_cnt;
            12'hFF1: return m_cmp;
            12'hFF2: return {23'd0, 5'(m_n), (m_n == 0), (m_n == DEPTH), m_ovf, m_hit};
            12'hFF4: return {16'd0, m_led};
            default: return 32'd0;
        endcase
    endfunction

    // Reference model: evaluates what the coming clock edge does, from the inputs now stable.
    always @(negedge clock) begin
        logic stb, w, ovf_set, eq;
        #1;
        if (reset) begin
            m_cnt = 32'd0; m_cmp = 32'hFFFF_FFFF; m_hit = 1'b0; m_ovf = 1'b0;
            m_n = 0; m_led = 16'd0; m_pc = 1'b0;
            exp_tx.delete();
            sb.delete();
        end else begin
            stb  = proc_clock && !m_pc;
            m_pc = proc_clock;
            if (rd_chk) sb.push_back('{due: cyc + 1, addr: address_dmem, val: m_read(address_dmem)});
            w = stb && wren;
            ovf_set = 1'b0;
            if (wren && address_dmem < 12'(RAM_WORDS)) m_ram[int'(address_dmem)] = data;
            if (m_n > 0 && tx_ready) m_n--;
            if (w && address_dmem == 12'hFF3) begin
                if (m_n < DEPTH) begin
                    m_n++;
                    exp_tx.push_back(data[7:0]);
                end else begin
                    ovf_set = 1'b1;
                end
            end
            eq    = (m_cnt == m_cmp);
            m_hit = eq || (m_hit && !(w && address_dmem == 12'hFF2 && data[0]));
            m_ovf = ovf_set || (m_ovf && !(w && address_dmem == 12'hFF2 && data[1]));
            m_cnt = (w && address_dmem == 12'hFF0) ? data : m_cnt + 32'd1;
            if (w && address_dmem == 12'hFF1) m_cmp = data;
            if (w && address_dmem == 12'hFF4) m_led = data[15:0];
        end
        cyc++;
    end

    // Monitor: read data, TX handshake and LED, sampled mid-cycle.
    always @(negedge clock) begin
        if (!reset) begin
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                exp_t e;
                e = sb.pop_front();
                chk($sformatf("q_dmem@%03h", e.addr), q_dmem, e.val);
            end
            chk("tx_valid", {31'd0, tx_valid}, {31'd0, exp_tx.size() != 0});
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) begin
                    total++; bad++;
                    $display("FAIL tx_pop: got %h want no data (t=%0t)", tx_data, $time);
                end else begin
                    chk("tx_data", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
                end
            end
            chk("led", {16'd0, led}, {16'd0, m_led});
        end
    end

    task automatic set_rdy(input int ph);
        case (rdy_mode)
            0:       tx_ready = 1'b0;
            1:       tx_ready = 1'b1;
            2:       tx_ready = 1'($urandom_range(0, 1));
            default: tx_ready = (ph == 0);
        endcase
    endtask

    // One processor cycle: 4 clocks, proc_clock high for the first two.
    task automatic acc(input logic [11:0] a, input logic [31:0] d, input logic w, input logic c);
        address_dmem = a; data = d; wren = w; rd_chk = c; proc_clock = 1'b1;
        set_rdy(0);
        @(posedge clock); #2; rd_chk = 1'b0; set_rdy(1);
        @(posedge clock); #2; proc_clock = 1'b0; set_rdy(2);
        @(posedge clock); #2; set_rdy(3);
        @(posedge clock); #2;
    endtask

    task automatic idle(input int n);
        wren = 1'b0; proc_clock = 1'b0; rd_chk = 1'b0;
        for (int i = 0; i < n; i++) begin
            set_rdy(1);
            @(posedge clock); #2;
        end
    endtask

    initial begin
        reset = 1'b1; proc_clock = 1'b0; wren = 1'b0; tx_ready = 1'b0;
        address_dmem = 12'd0; data = 32'd0; rd_chk = 1'b0; rdy_mode = 0;
        repeat (3) @(posedge clock);
        #2;
        chk("q_dmem_rst", q_dmem, 32'd0);
        chk("tx_data_rst", {24'd0, tx_data}, 32'd0);
        reset = 1'b0;

        acc(12'hFF2, 32'd0, 1'b0, 1'b1);
        acc(12'hFF1, 32'd0, 1'b0, 1'b1);
        acc(12'hFF4, 32'd0, 1'b0, 1'b1);

        for (int i = 0; i < 16; i++) acc(12'(i), $urandom(), 1'b1, 1'b0);
        acc(12'h7FF, $urandom(), 1'b1, 1'b0);
        acc(12'd5, 32'hDEAD_BEEF, 1'b1, 1'b0);
        acc(12'd5, 32'd0, 1'b0, 1'b1);
        acc(12'h7FF, 32'd0, 1'b0, 1'b1);
        acc(12'h800, 32'h1234_5678, 1'b1, 1'b0);
        acc(12'h800, 32'd0, 1'b0, 1'b1);
        acc(12'hFFA, 32'd0, 1'b0, 1'b1);

        // Fill past full with the sink stalled, then drain.
        rdy_mode = 0;
        for (int i = 0; i < 9; i++) acc(12'hFF3, 32'h41 + 32'(i), 1'b1, 1'b0);
        acc(12'hFF2, 32'd0, 1'b0, 1'b1);
        acc(12'hFF3, 32'd0, 1'b0, 1'b1);
        rdy_mode = 1; idle(12); rdy_mode = 0;
        acc(12'hFF2, 32'd0, 1'b0, 1'b1);
        acc(12'hFF2, 32'h3, 1'b1, 1'b0);
        acc(12'hFF2, 32'd0, 1'b0, 1'b1);

        // Push on full with a simultaneous pop.
        for (int i = 0; i < 8; i++) acc(12'hFF3, 32'h50 + 32'(i), 1'b1, 1'b0);
        rdy_mode = 3; acc(12'hFF3, 32'h58, 1'b1, 1'b0);
        rdy_mode = 0; acc(12'hFF2, 32'd0, 1'b0, 1'b1);
        rdy_mode = 1; idle(12); rdy_mode = 0;

        // Timer compare, W1C, and set-beats-clear.
        acc(12'hFF1, 32'd20, 1'b1, 1'b0);
        acc(12'hFF0, 32'd0, 1'b1, 1'b0);
        acc(12'hFF2, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) acc(12'hFF0, 32'd0, 1'b0, 1'b1);
        acc(12'hFF2, 32'd0, 1'b0, 1'b1);
        acc(12'hFF2, 32'h1, 1'b1, 1'b0);
        acc(12'hFF2, 32'd0, 1'b0, 1'b1);
        acc(12'hFF1, 32'd3, 1'b1, 1'b0);
        acc(12'hFF0, 32'd0, 1'b1, 1'b0);
        acc(12'hFF2, 32'h1, 1'b1, 1'b0);
        acc(12'hFF2, 32'd0, 1'b0, 1'b1);
        acc(12'hFF2, 32'h1, 1'b1, 1'b0);
        acc(12'hFF2, 32'd0, 1'b0, 1'b1);
        acc(12'hFF1, 32'hFFFF_FFFF, 1'b1, 1'b0);

        // One store held for a full processor cycle pushes once; LED store.
        acc(12'hFF3, 32'h77, 1'b1, 1'b0);
        acc(12'hFF2, 32'd0, 1'b0, 1'b1);
        rdy_mode = 1; idle(4); rdy_mode = 0;
        acc(12'hFF4, 32'h0001_A5A5, 1'b1, 1'b0);
        chk("led_a5a5", {16'd0, led}, 32'h0000_A5A5);
        acc(12'hFF4, 32'd0, 1'b0, 1'b1);

        // Randomised traffic with a randomly stalling sink.
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            logic [11:0] a;
            case ($urandom_range(0, 9))
                0, 1, 2, 3: a = 12'($urandom_range(0, 15));
                4:          a = 12'h7FF;
                5:          a = 12'($urandom_range(12'h800, 12'hFEF));
                6:          a = 12'($urandom_range(12'hFF0, 12'hFFF));
                7:          a = 12'hFF3;
                8:          a = 12'hFF2;
                default:    a = 12'hFF4;
            endcase
            acc(a, $urandom(), 1'($urandom_range(0, 1)), 1'b1);
        end
        rdy_mode = 1; idle(12);

        // Asynchronous reset with bytes queued.
        rdy_mode = 0;
        acc(12'hFF4, 32'h0000_1234, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) acc(12'hFF3, 32'hC0 + 32'(i), 1'b1, 1'b0);
        @(posedge clock); #3;
        wren = 1'b0; proc_clock = 1'b0;
        reset = 1'b1;
        #1;
        exp_tx.delete(); sb.delete();
        chk("tx_valid_async_rst", {31'd0, tx_valid}, 32'd0);
        chk("led_async_rst", {16'd0, led}, 32'd0);
        chk("q_dmem_async_rst", q_dmem, 32'd0);
        @(posedge clock); @(posedge clock); #3;
        reset = 1'b0;
        @(posedge clock); #2;
        acc(12'hFF2, 32'd0, 1'b0, 1'b1);
        acc(12'hFF1, 32'd0, 1'b0, 1'b1);
        acc(12'd5, 32'd0, 1'b0, 1'b1);
        acc(12'h7FF, 32'd0, 1'b0, 1'b1);
        idle(3);

        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL sb_drain: got %0d pending reads want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
